// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue.
// `XLEN : PC / instruction width used across the fetch path
// `NOP  : canonical no-op encoding (addi x0, x0, 0)
// The package carries the default geometry of the queue.
`ifndef IF_FETCH_QUEUE_DEFINES
`define IF_FETCH_QUEUE_DEFINES
`define XLEN 32
`define NOP 32'h00000013
`endif

package if_fetch_queue_pkg;
   localparam int unsigned IFQ_XLEN  = `XLEN;
   localparam int unsigned IFQ_DEPTH = 4;
   localparam int unsigned IFQ_AW    = $clog2(IFQ_DEPTH);
endpackage

// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue between the PC generator and decode.
// Issues in-order icache requests for i_pc and buffers PC/instruction
// pairs in a DEPTH-entry circular queue. The head entry is offered to
// decode via o_id_valid/i_id_ready. i_flush drops all queued entries and
// remembers how many in-flight responses must be discarded (kill_cnt).
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_pc, i_pc_valid, o_halt           PC generator side
//   i_flush                            redirect, kills everything older
//   o_ic_req, o_ic_addr, i_ic_gnt      icache request channel
//   i_ic_rvalid, i_ic_rdata            icache in-order response channel
//   o_id_valid, o_id_pc, o_id_instr,
//   i_id_ready                         decode handshake
//   o_count                            allocated entries
module if_fetch_queue
   import if_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = IFQ_DEPTH,
   parameter int unsigned AW    = IFQ_AW,
   parameter int unsigned XLEN  = IFQ_XLEN
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_pc_valid,
   input  logic            i_flush,
   output logic            o_halt,
   output logic            o_ic_req,
   output logic [XLEN-1:0] o_ic_addr,
   input  logic            i_ic_gnt,
   input  logic            i_ic_rvalid,
   input  logic [XLEN-1:0] i_ic_rdata,
   output logic            o_id_valid,
   output logic [XLEN-1:0] o_id_pc,
   output logic [XLEN-1:0] o_id_instr,
   input  logic            i_id_ready,
   output logic [AW:0]     o_count
);

   localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   fill_ptr_q, fill_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [AW:0]     unfilled_q, unfilled_d;
   logic [AW:0]     kill_cnt_q, kill_cnt_d;

   logic [XLEN-1:0] pc_q    [DEPTH];
   logic [XLEN-1:0] pc_d    [DEPTH];
   logic [XLEN-1:0] instr_q [DEPTH];
   logic [XLEN-1:0] instr_d [DEPTH];
   logic [DEPTH-1:0] filled_q, filled_d;

   logic space;
   logic issue;
   logic deq;
   logic resp_keep;
   logic resp_kill;

   assign o_ic_addr  = i_pc;
   assign o_id_pc    = pc_q[rd_ptr_q];
   assign o_id_instr = instr_q[rd_ptr_q];
   assign o_count    = count_q;

   always_comb begin
      // Slots still owed to killed responses count as occupied so the
      // icache never has more than DEPTH responses outstanding.
      space      = ({1'b0, count_q} + {1'b0, kill_cnt_q}) < DEPTH_W;
      o_ic_req   = i_pc_valid & space & ~i_flush & ~i_rst;
      issue      = o_ic_req & i_ic_gnt;
      o_halt     = i_rst | (~i_flush & ~issue);
      o_id_valid = filled_q[rd_ptr_q] & (count_q != '0) & ~i_flush & ~i_rst;
      deq        = o_id_valid & i_id_ready;
      resp_kill  = i_ic_rvalid & (kill_cnt_q != '0);
      resp_keep  = i_ic_rvalid & (kill_cnt_q == '0);

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fill_ptr_d = fill_ptr_q;
      count_d    = count_q;
      unfilled_d = unfilled_q;
      kill_cnt_d = kill_cnt_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      filled_d   = filled_q;

      if (i_flush) begin
         // A response in the flush cycle belongs to an older fetch and is
         // dropped here, so it is not added to the kill debt.
         rd_ptr_d   = wr_ptr_q;
         fill_ptr_d = wr_ptr_q;
         count_d    = '0;
         unfilled_d = '0;
         kill_cnt_d = kill_cnt_q + unfilled_q - (AW+1)'(i_ic_rvalid);
      end else begin
         if (issue) begin
            pc_d[wr_ptr_q]     = i_pc;
            filled_d[wr_ptr_q] = 1'b0;
            wr_ptr_d           = wr_ptr_q + 1'b1;
         end
         if (resp_kill) begin
            kill_cnt_d = kill_cnt_q - 1'b1;
         end else if (resp_keep) begin
            instr_d[fill_ptr_q]  = i_ic_rdata;
            filled_d[fill_ptr_q] = 1'b1;
            fill_ptr_d           = fill_ptr_q + 1'b1;
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d    = count_q + (AW+1)'(issue) - (AW+1)'(deq);
         unfilled_d = unfilled_q + (AW+1)'(issue) - (AW+1)'(resp_keep);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_ptr_q <= '0;
         count_q    <= '0;
         unfilled_q <= '0;
         kill_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_ptr_q <= fill_ptr_d;
         count_q    <= count_d;
         unfilled_q <= unfilled_d;
         kill_cnt_q <= kill_cnt_d;
      end
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      filled_q <= filled_d;
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [31:0] i_pc;
   logic        i_pc_valid;
   logic        i_flush;
   logic        o_halt;
   logic        o_ic_req;
   logic [31:0] o_ic_addr;
   logic        i_ic_gnt;
   logic        i_ic_rvalid;
   logic [31:0] i_ic_rdata;
   logic        o_id_valid;
   logic [31:0] o_id_pc;
   logic [31:0] o_id_instr;
   logic        i_id_ready;
   logic [2:0]  o_count;

   if_fetch_queue dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_pc(i_pc), .i_pc_valid(i_pc_valid),
      .i_flush(i_flush), .o_halt(o_halt), .o_ic_req(o_ic_req),
      .o_ic_addr(o_ic_addr), .i_ic_gnt(i_ic_gnt), .i_ic_rvalid(i_ic_rvalid),
      .i_ic_rdata(i_ic_rdata), .o_id_valid(o_id_valid), .o_id_pc(o_id_pc),
      .o_id_instr(o_id_instr), .i_id_ready(i_id_ready), .o_count(o_count)
   );

   always #5 i_clk = ~i_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: queue of allocated entries, filled ones form a prefix
   logic [31:0] mq_pc[$];
   logic [31:0] mq_in[$];
   int          nfill = 0;
   int          kill  = 0;
   // icache model: addresses granted and not yet answered
   logic [31:0] icq[$];
   // what decode actually consumed
   logic [31:0] dec_pc[$];
   logic [31:0] dec_in[$];

   logic resp_en;
   logic auto_pc;
   logic ob_req, ob_halt, ob_idv;
   logic [31:0] ob_addr;
   logic [2:0]  ob_cnt;
   logic        halt_seen;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return `NOP ^ (a << 7) ^ (a * 32'h9E3779B1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq_pc.delete(); mq_in.delete(); icq.delete();
      nfill = 0; kill = 0;
   endtask

   task automatic step();
      int sz;
      logic sp, e_req, e_iss, e_halt, e_idv, e_deq, rv;
      logic [31:0] rd, cur_pc;
      i_rst       = 1'b0;
      i_ic_rvalid = resp_en && (icq.size() > 0);
      i_ic_rdata  = i_ic_rvalid ? instr_of(icq[0]) : 32'hDEADBEEF;
      #2;
      sz     = mq_pc.size();
      sp     = (sz + kill) < 4;
      e_req  = i_pc_valid & sp & ~i_flush;
      e_iss  = e_req & i_ic_gnt;
      e_halt = ~i_flush & ~e_iss;
      e_idv  = (nfill > 0) & ~i_flush;
      chk("ic_req", 32'(o_ic_req), 32'(e_req));
      chk("halt", 32'(o_halt), 32'(e_halt));
      if (e_req) chk("ic_addr", o_ic_addr, i_pc);
      chk("id_valid", 32'(o_id_valid), 32'(e_idv));
      if (e_idv) begin
         chk("id_pc", o_id_pc, mq_pc[0]);
         chk("id_instr", o_id_instr, mq_in[0]);
      end
      chk("count", 32'(o_count), 32'(sz));
      ob_req = o_ic_req; ob_halt = o_halt; ob_idv = o_id_valid;
      ob_addr = o_ic_addr; ob_cnt = o_count;
      if (o_halt) halt_seen = 1'b1;
      if (o_id_valid && i_id_ready) begin
         dec_pc.push_back(o_id_pc);
         dec_in.push_back(o_id_instr);
      end
      e_deq  = e_idv & i_id_ready;
      rv     = i_ic_rvalid;
      rd     = i_ic_rdata;
      cur_pc = i_pc;
      @(posedge i_clk);
      if (i_flush) begin
         kill = kill + (sz - nfill) - (rv ? 1 : 0);
         mq_pc.delete(); mq_in.delete(); nfill = 0;
      end else begin
         if (rv) begin
            if (kill > 0) kill--;
            else begin mq_in[nfill] = rd; nfill++; end
         end
         if (e_deq) begin
            void'(mq_pc.pop_front()); void'(mq_in.pop_front()); nfill--;
         end
         if (e_iss) begin mq_pc.push_back(cur_pc); mq_in.push_back(32'h0); end
      end
      if (rv) void'(icq.pop_front());
      if (e_iss) icq.push_back(cur_pc);
      #1;
      if (auto_pc && e_iss) i_pc = i_pc + 1;
   endtask

   task automatic rst_step();
      i_rst = 1'b1; i_flush = 1'b0; i_ic_rvalid = 1'b0;
      #2;
      chk("rst_req", 32'(o_ic_req), 32'd0);
      chk("rst_idv", 32'(o_id_valid), 32'd0);
      chk("rst_halt", 32'(o_halt), 32'd1);
      @(posedge i_clk);
      model_clear();
      #1;
      chk("rst_count", 32'(o_count), 32'd0);
   endtask

   task automatic drain();
      auto_pc = 1'b0; i_pc_valid = 1'b0; i_flush = 1'b0;
      resp_en = 1'b1; i_id_ready = 1'b1;
      for (int k = 0; k < 10; k++) step();
      dec_pc.delete(); dec_in.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      i_rst = 1'b1; i_pc = '0; i_pc_valid = 1'b0; i_flush = 1'b0;
      i_ic_gnt = 1'b0; i_ic_rvalid = 1'b0; i_ic_rdata = '0; i_id_ready = 1'b0;
      resp_en = 1'b0; auto_pc = 1'b0; halt_seen = 1'b0;
      @(posedge i_clk); #1;

      // reset, then streaming with 1-cycle response latency
      rst_step(); rst_step();
      i_pc = 32'd0; i_pc_valid = 1'b1; i_ic_gnt = 1'b1;
      resp_en = 1'b1; i_id_ready = 1'b1; auto_pc = 1'b1;
      halt_seen = 1'b0;
      step();
      chk("rel_req", 32'(ob_req), 32'd1);
      chk("rel_addr", ob_addr, 32'd0);
      chk("rel_halt", 32'(ob_halt), 32'd0);
      for (int k = 0; k < 7; k++) step();
      chk("stream_halt", 32'(halt_seen), 32'd0);
      chk("stream_n", 32'(dec_pc.size() >= 4), 32'd1);
      for (int k = 0; k < 4; k++) begin
         if (dec_pc.size() > k) begin
            chk("stream_pc", dec_pc[k], 32'(k));
            chk("stream_in", dec_in[k], instr_of(32'(k)));
         end
      end

      // full queue
      drain();
      i_pc = 32'd40; auto_pc = 1'b1; i_pc_valid = 1'b1; i_ic_gnt = 1'b1;
      i_id_ready = 1'b0;
      for (int k = 0; k < 6; k++) step();
      chk("full_cnt", 32'(ob_cnt), 32'd4);
      chk("full_req", 32'(ob_req), 32'd0);
      chk("full_halt", 32'(ob_halt), 32'd1);
      i_id_ready = 1'b1; step();
      i_id_ready = 1'b0; step();
      chk("free_cnt", 32'(ob_cnt), 32'd3);
      chk("free_req", 32'(ob_req), 32'd1);
      step();
      chk("refill_cnt", 32'(ob_cnt), 32'd4);

      // grant stall
      drain();
      i_pc = 32'd8; i_pc_valid = 1'b1; i_ic_gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_halt", 32'(ob_halt), 32'd1);
         chk("stall_addr", ob_addr, 32'd8);
      end
      i_ic_gnt = 1'b1; step();
      chk("gnt_halt", 32'(ob_halt), 32'd0);
      i_pc_valid = 1'b0;
      for (int k = 0; k < 4; k++) step();
      chk("stall_n", 32'(dec_pc.size()), 32'd1);
      if (dec_pc.size() > 0) chk("stall_pc", dec_pc[0], 32'd8);

      // flush with two fills pending
      drain();
      resp_en = 1'b0; i_ic_gnt = 1'b1; i_pc_valid = 1'b1;
      i_pc = 32'd4; step();
      i_pc = 32'd5; step();
      i_flush = 1'b1; i_pc = 32'd20; step();
      chk("fl_halt", 32'(ob_halt), 32'd0);
      chk("fl_req", 32'(ob_req), 32'd0);
      i_flush = 1'b0; resp_en = 1'b1; step();
      chk("fl_cnt", 32'(ob_cnt), 32'd0);
      i_pc_valid = 1'b0;
      for (int k = 0; k < 6; k++) step();
      chk("fl_n", 32'(dec_pc.size()), 32'd1);
      if (dec_pc.size() > 0) begin
         chk("fl_pc", dec_pc[0], 32'd20);
         chk("fl_in", dec_in[0], instr_of(32'd20));
      end

      // flush coincident with a response, one more fill beyond it
      drain();
      resp_en = 1'b0; i_ic_gnt = 1'b1; i_pc_valid = 1'b1;
      i_pc = 32'd4; step();
      i_pc = 32'd5; step();
      resp_en = 1'b1; i_flush = 1'b1; i_pc = 32'd30; step();
      i_flush = 1'b0; step();
      i_pc_valid = 1'b0;
      for (int k = 0; k < 6; k++) step();
      chk("flr_n", 32'(dec_pc.size()), 32'd1);
      if (dec_pc.size() > 0) begin
         chk("flr_pc", dec_pc[0], 32'd30);
         chk("flr_in", dec_in[0], instr_of(32'd30));
      end

      // randomized traffic against the model, with one reset mid-stream
      drain();
      auto_pc = 1'b1;
      for (int c = 0; c < 500; c++) begin
         if (c == 250) begin rst_step(); rst_step(); end
         i_pc_valid = ($urandom_range(0, 9) != 0);
         i_ic_gnt   = ($urandom_range(0, 3) != 0);
         resp_en    = ($urandom_range(0, 2) != 0);
         i_id_ready = ($urandom_range(0, 3) != 0);
         i_flush    = ($urandom_range(0, 19) == 0);
         if (i_flush) i_pc = $urandom;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
